// File: rtl/sw_test_status_pkg.sv
// Shared status codes, channel state encoding and log helpers for the
// software test-status monitor.
package sw_test_status_pkg;

  localparam logic [15:0] IN_BOOT = 16'hb090;
  localparam logic [15:0] IN_TEST = 16'h4354;
  localparam logic [15:0] IN_WFI  = 16'h1d1e;
  localparam logic [15:0] PASSED  = 16'h900d;
  localparam logic [15:0] FAILED  = 16'hbaad;

  localparam int unsigned LOG_CHAN_W = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } sts_state_e;

  // Channel index field of a history entry; the word field width is DW,
  // so the full entry struct is declared where DW is known.
  typedef logic [LOG_CHAN_W-1:0] log_chan_t;

  function automatic logic is_done(sts_state_e s);
    return (s == PASS) || (s == FAIL);
  endfunction

endpackage

// File: rtl/sw_test_status_mon_if.sv
// Status-write and status-report bundle of the test-status monitor.
interface sw_test_status_mon_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned DW  = 32
);
  logic [NCH-1:0]      wr_valid_i;
  logic [NCH*DW-1:0]   wr_data_i;
  logic [NCH*DW-1:0]   status_o;
  logic [NCH*2-1:0]    state_o;
  logic [NCH-1:0]      timeout_o;
  logic [NCH-1:0]      late_wr_o;
  logic                all_done_o;
  logic                all_pass_o;
  logic                log_pop_i;
  logic                log_valid_o;
  logic [4+DW-1:0]     log_data_o;
  logic                log_drop_o;

  modport master (
    output wr_valid_i, wr_data_i, log_pop_i,
    input  status_o, state_o, timeout_o, late_wr_o, all_done_o, all_pass_o,
           log_valid_o, log_data_o, log_drop_o
  );

  modport slave (
    input  wr_valid_i, wr_data_i, log_pop_i,
    output status_o, state_o, timeout_o, late_wr_o, all_done_o, all_pass_o,
           log_valid_o, log_data_o, log_drop_o
  );
endinterface

// File: rtl/sw_test_status_chan.sv
// One status channel: BOOT/RUN/PASS/FAIL tracker with RUN-state watchdog.
// Exposes its next state so the top can register aggregates in step.
module sw_test_status_chan
  import sw_test_status_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] status,
  output sts_state_e    state,
  output sts_state_e    state_nxt,
  output logic          timeout,
  output logic          late_wr,
  output logic          accept
);

  localparam int unsigned    WDW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYC);

  logic [WDW-1:0] wd, wd_nxt;
  logic [DW-1:0]  status_nxt;
  logic           timeout_nxt, late_nxt;
  logic [15:0]    code;

  assign code = wr_data[15:0];

  always_comb begin
    state_nxt   = state;
    status_nxt  = status;
    timeout_nxt = timeout;
    late_nxt    = late_wr;
    wd_nxt      = '0;
    accept      = 1'b0;
    case (state)
      BOOT: begin
        if (wr_valid) begin
          accept     = 1'b1;
          status_nxt = wr_data;
          if (code == IN_TEST)     state_nxt = RUN;
          else if (code == PASSED) state_nxt = PASS;
          else if (code == FAILED) state_nxt = FAIL;
        end
      end
      RUN: begin
        // A write in the expiry cycle wins: counter stays cleared.
        if (wr_valid) begin
          accept     = 1'b1;
          status_nxt = wr_data;
          if (code == PASSED)      state_nxt = PASS;
          else if (code == FAILED) state_nxt = FAIL;
        end else if (TIMEOUT_CYC != 0) begin
          wd_nxt = (wd == WD_LIMIT) ? wd : wd + WDW'(1);
          if (wd_nxt == WD_LIMIT) begin
            state_nxt   = FAIL;
            timeout_nxt = 1'b1;
          end
        end
      end
      PASS, FAIL: begin
        if (wr_valid) late_nxt = 1'b1;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= BOOT;
      status  <= '0;
      wd      <= '0;
      timeout <= 1'b0;
      late_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      status  <= status_nxt;
      wd      <= wd_nxt;
      timeout <= timeout_nxt;
      late_wr <= late_nxt;
    end
  end

endmodule

// File: rtl/sw_test_status_mon.sv
// Multi-channel software test-status monitor with aggregate done/pass flags.
// Optional history FIFO enabled by defining SW_TEST_STATUS_LOG_EN.
module sw_test_status_mon
  import sw_test_status_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned LOG_DEPTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sw_test_status_mon_if.slave  bus
);

  typedef struct packed {
    log_chan_t     chan;
    logic [DW-1:0] word;
  } log_entry_t;

  sts_state_e     st     [NCH];
  sts_state_e     st_nxt [NCH];
  logic [NCH-1:0] accept;
  logic [NCH-1:0] done_nxt, pass_nxt;
  logic           all_done, all_pass;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    sw_test_status_chan #(
      .DW          (DW),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_valid  (bus.wr_valid_i[c]),
      .wr_data   (bus.wr_data_i[c*DW +: DW]),
      .status    (bus.status_o[c*DW +: DW]),
      .state     (st[c]),
      .state_nxt (st_nxt[c]),
      .timeout   (bus.timeout_o[c]),
      .late_wr   (bus.late_wr_o[c]),
      .accept    (accept[c])
    );
    assign bus.state_o[c*2 +: 2] = st[c];
    assign done_nxt[c] = is_done(st_nxt[c]);
    assign pass_nxt[c] = (st_nxt[c] == PASS);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      all_done <= 1'b0;
      all_pass <= 1'b0;
    end else begin
      all_done <= &done_nxt;
      all_pass <= &pass_nxt;
    end
  end

  assign bus.all_done_o = all_done;
  assign bus.all_pass_o = all_pass;

`ifdef SW_TEST_STATUS_LOG_EN
  localparam int unsigned AW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  log_entry_t    mem [LOG_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, multi, full, do_push, do_pop, drop;
  log_chan_t     sel;
  logic [DW-1:0] push_word;

  // Lowest-index accepted write is the one logged.
  always_comb begin
    push      = 1'b0;
    sel       = '0;
    push_word = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (accept[i] && !push) begin
        push      = 1'b1;
        sel       = log_chan_t'(i);
        push_word = bus.wr_data_i[i*DW +: DW];
      end
    end
  end

  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
    return (p == AW'(LOG_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign multi   = ($countones(accept) > 1);
  assign full    = (count == (AW+1)'(LOG_DEPTH));
  assign do_pop  = bus.log_pop_i && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
      if (multi || (push && !do_push)) drop <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= '{chan: sel, word: push_word};
  end

  assign bus.log_valid_o = (count != '0);
  assign bus.log_data_o  = mem[rd_ptr];
  assign bus.log_drop_o  = drop;
`else
  logic unused_log;
  assign unused_log      = ^{accept, bus.log_pop_i, (LOG_DEPTH != 0)};
  assign bus.log_valid_o = 1'b0;
  assign bus.log_data_o  = '0;
  assign bus.log_drop_o  = 1'b0;
`endif

endmodule
